adxl362_spi_responder: RTL and testbench
========================================

ADXL362_SPI_RESPONDER -- requirements
Module: adxl362_spi_responder

Interface
REQ-001 Parameter DEVID_AD, 8'hAD, value returned at register 0x00.
REQ-002 Parameter DEVID_MST, 8'h1D, value returned at register 0x01.
REQ-003 Parameter PARTID, 8'hF2, value returned at register 0x02.
REQ-004 clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 spi_cs_n  input  1  SPI chip select, active low, asynchronous to clk.
REQ-007 spi_sclk  input  1  SPI clock (mode 0), asynchronous to clk, at most clk/8.
REQ-008 spi_mosi  input  1  serial data in, MSB first.
REQ-009 spi_miso  output  1  serial data out, MSB first.
REQ-010 x_in, y_in, z_in  input  16 each  signed live axis samples.
REQ-011 power_ctl  output  8  current POWER_CTL register (0x2D).
REQ-012 measure_en  output  1  high when power_ctl[1:0] == 2'b10.
REQ-013 reg_wr  output  1  one-cycle pulse per accepted register write.
REQ-014 reg_wr_addr / reg_wr_data  output  8 / 8  address and data of the write pulsed on reg_wr.

Function
REQ-015 spi_cs_n, spi_sclk, spi_mosi SHALL each pass a 2-flop synchronizer; edges detected on synchronized values.
REQ-016 MOSI SHALL be sampled on each synchronized SCLK rising edge while CS low; 8 samples form one byte.
REQ-017 FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
REQ-018 IDLE -> CMD on synchronized CS falling edge; bit counter cleared, axis inputs snapshotted into shadow registers 0x0E..0x13 (X_L,X_H,Y_L,Y_H,Z_L,Z_H, little-endian) in that cycle.
REQ-019 CMD: byte 0x0A -> ADDR (write); 0x0B -> ADDR (read); any other byte -> IGNORE.
REQ-020 ADDR: received byte loads 8-bit address pointer; -> WDATA for write, -> RDATA for read.
REQ-021 WDATA: each complete byte written to pointer address, reg_wr pulsed within 2 clk of the 8th SCLK rise, pointer +1.
REQ-022 Writable registers: 0x1F SOFT_RESET, 0x2C FILTER_CTL (reset 8'h13), 0x2D POWER_CTL (reset 8'h00); writes elsewhere ignored but still pulse reg_wr.
REQ-023 Writing 8'h52 to 0x1F SHALL restore FILTER_CTL and POWER_CTL to reset values; SOFT_RESET reads 0x00.
REQ-024 RDATA: on SCLK falling edge following the 8th rise of the address byte, load shift register with register[pointer], drive MSB; each subsequent falling edge shifts next bit; after 8th rise of each byte pointer +1 and next byte loads on the following falling edge.
REQ-025 Read map: 0x00..0x02 parameters, 0x0E..0x13 shadows, 0x2C, 0x2D; all other addresses read 0x00.
REQ-026 Pointer increments modulo 256 (0xFF -> 0x00).
REQ-027 spi_miso SHALL be 0 in IDLE, CMD, ADDR, WDATA, IGNORE.
REQ-028 Synchronized CS rising edge in any state -> IDLE; partial byte discarded, no write issued, miso 0.
REQ-029 IGNORE holds until CS rises; no writes, miso 0.
REQ-030 Shadows unchanged during a transaction regardless of axis input changes.

Reset
REQ-031 On reset: state IDLE, spi_miso 0, power_ctl 8'h00, FILTER_CTL 8'h13, measure_en 0, reg_wr 0, reg_wr_addr/data 8'h00, shadows 0, pointer 0, synchronizers to CS=1/SCLK=0/MOSI=0.
REQ-032 Reset asserted mid-transaction SHALL abort it; after release, next CS falling edge starts a fresh transaction.

Verification
REQ-033 Write 0x0A,0x2D,0x02 -> reg_wr once with addr 0x2D data 0x02; power_ctl=0x02; measure_en=1.
REQ-034 z_in=16'hFF38, read 0x0B,0x12,0x00,0x00 -> MISO bytes 0x38,0xFF; changing z_in mid-transaction has no effect.
REQ-035 Read 0x0B,0x00 then 3 dummy bytes -> 0xAD,0x1D,0xF2; read at 0xFF then 2 bytes -> 0x00,0xAD (wrap).
REQ-036 CS raised after 5 bits of write data byte -> no reg_wr, power_ctl unchanged.
REQ-037 Command byte 0x55 then 0x2D,0x02 -> no write, miso 0 throughout; then write 0x52 to 0x1F after POWER_CTL=0x02 -> power_ctl 0x00.
REQ-038 Reset pulse mid-read -> miso 0, state IDLE; following read of 0x2D returns 0x00.

Source files
------------

// File: rtl/adxl362_spi_responder.sv
// Purpose: SPI slave that emulates the ADXL362 register interface (ID, axis shadows, FILTER_CTL, POWER_CTL).
// Latency: register write pulses 1 clk after the synchronized 8th SCLK rise; MISO updates 1 clk after a synchronized SCLK fall.
// Backpressure: none; the SPI master owns the pace and SCLK must stay at or below clk/8.
module adxl362_spi_responder #(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               spi_cs_n,
    input  logic               spi_sclk,
    input  logic               spi_mosi,
    output logic               spi_miso,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    input  logic signed [15:0] z_in,
    output logic [7:0]         power_ctl,
    output logic               measure_en,
    output logic               reg_wr,
    output logic [7:0]         reg_wr_addr,
    output logic [7:0]         reg_wr_data
);

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] ADDR_SOFT_RST  = 8'h1F;
    localparam logic [7:0] ADDR_FILTER    = 8'h2C;
    localparam logic [7:0] ADDR_POWER     = 8'h2D;
    localparam logic [7:0] SOFT_RST_KEY   = 8'h52;
    localparam logic [7:0] FILTER_RST_VAL = 8'h13;
    localparam logic [7:0] POWER_RST_VAL  = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

    // Synchronizer stages plus one extra flop per edge-detected signal
    logic [1:0] cs_sync;
    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic       cs_q;
    logic       sclk_q;

    logic cs_s, sclk_s, mosi_s;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    state_t     state;
    logic       is_read;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic [7:0] ptr;
    logic [7:0] tx_shift;
    logic       load_pend;
    logic [7:0] filter_ctl;
    logic [7:0] shadow [6];
    logic [7:0] rd_data;

    // Two-flop synchronizers for the asynchronous SPI pins, idle-level reset values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync   <= 2'b11;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], spi_cs_n};
            sclk_sync <= {sclk_sync[0], spi_sclk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            cs_q      <= cs_sync[1];
            sclk_q    <= sclk_sync[1];
        end
    end

    assign cs_s      = cs_sync[1];
    assign sclk_s    = sclk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign cs_fall   = cs_q & ~cs_s;
    assign cs_rise   = ~cs_q & cs_s;
    assign sclk_rise = ~sclk_q & sclk_s & ~cs_s;
    assign sclk_fall = sclk_q & ~sclk_s & ~cs_s;
    assign rx_byte   = {rx_shift, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);

    assign measure_en = (power_ctl[1:0] == 2'b10);

    // Register read map addressed by the auto-incrementing pointer
    always_comb begin
        rd_data = 8'h00;
        case (ptr)
            8'h00:       rd_data = DEVID_AD;
            8'h01:       rd_data = DEVID_MST;
            8'h02:       rd_data = PARTID;
            8'h0E:       rd_data = shadow[0];
            8'h0F:       rd_data = shadow[1];
            8'h10:       rd_data = shadow[2];
            8'h11:       rd_data = shadow[3];
            8'h12:       rd_data = shadow[4];
            8'h13:       rd_data = shadow[5];
            ADDR_FILTER: rd_data = filter_ctl;
            ADDR_POWER:  rd_data = power_ctl;
            default:     rd_data = 8'h00;
        endcase
    end

    // Transaction FSM: byte assembly, command decode, register writes and MISO shifting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            is_read     <= 1'b0;
            bit_cnt     <= 3'd0;
            rx_shift    <= 7'd0;
            ptr         <= 8'h00;
            tx_shift    <= 8'h00;
            load_pend   <= 1'b0;
            spi_miso    <= 1'b0;
            filter_ctl  <= FILTER_RST_VAL;
            power_ctl   <= POWER_RST_VAL;
            reg_wr      <= 1'b0;
            reg_wr_addr <= 8'h00;
            reg_wr_data <= 8'h00;
            for (int i = 0; i < 6; i++) shadow[i] <= 8'h00;
        end else begin
            reg_wr <= 1'b0;
            if (cs_rise) begin
                // End of transaction from any state drops any partial byte
                state     <= IDLE;
                bit_cnt   <= 3'd0;
                load_pend <= 1'b0;
                spi_miso  <= 1'b0;
            end else if (state == IDLE) begin
                if (cs_fall) begin
                    state     <= CMD;
                    bit_cnt   <= 3'd0;
                    shadow[0] <= x_in[7:0];
                    shadow[1] <= x_in[15:8];
                    shadow[2] <= y_in[7:0];
                    shadow[3] <= y_in[15:8];
                    shadow[4] <= z_in[7:0];
                    shadow[5] <= z_in[15:8];
                end
            end else begin
                if (sclk_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state)
                        CMD: begin
                            if (rx_byte == CMD_WRITE) begin
                                is_read <= 1'b0;
                                state   <= ADDR;
                            end else if (rx_byte == CMD_READ) begin
                                is_read <= 1'b1;
                                state   <= ADDR;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                        ADDR: begin
                            ptr       <= rx_byte;
                            state     <= is_read ? RDATA : WDATA;
                            load_pend <= is_read;
                        end
                        WDATA: begin
                            reg_wr      <= 1'b1;
                            reg_wr_addr <= ptr;
                            reg_wr_data <= rx_byte;
                            ptr         <= ptr + 8'd1;
                            if (ptr == ADDR_FILTER) begin
                                filter_ctl <= rx_byte;
                            end else if (ptr == ADDR_POWER) begin
                                power_ctl <= rx_byte;
                            end else if (ptr == ADDR_SOFT_RST && rx_byte == SOFT_RST_KEY) begin
                                filter_ctl <= FILTER_RST_VAL;
                                power_ctl  <= POWER_RST_VAL;
                            end
                        end
                        RDATA: begin
                            ptr       <= ptr + 8'd1;
                            load_pend <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Mode 0: the next bit goes out on the falling edge so it is stable at the rise
                if (state == RDATA && sclk_fall) begin
                    if (load_pend) begin
                        tx_shift  <= rd_data;
                        spi_miso  <= rd_data[7];
                        load_pend <= 1'b0;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        spi_miso <= tx_shift[6];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Purpose: randomized and directed bench for adxl362_spi_responder against a register-map reference model.
// Latency: SPI driven at clk/16 with MISO sampled just before each SCLK rise.
// Backpressure: n/a; bench is the SPI master.
module tb_adxl362_spi_responder;

    localparam time HALF = 80ns;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               spi_cs_n = 1'b1;
    logic               spi_sclk = 1'b0;
    logic               spi_mosi = 1'b0;
    logic               spi_miso;
    logic signed [15:0] x_in = '0;
    logic signed [15:0] y_in = '0;
    logic signed [15:0] z_in = '0;
    logic [7:0]         power_ctl;
    logic               measure_en;
    logic               reg_wr;
    logic [7:0]         reg_wr_addr;
    logic [7:0]         reg_wr_data;

    adxl362_spi_responder dut (
        .clk         (clk),
        .reset       (reset),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .x_in        (x_in),
        .y_in        (y_in),
        .z_in        (z_in),
        .power_ctl   (power_ctl),
        .measure_en  (measure_en),
        .reg_wr      (reg_wr),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data)
    );

    always #5ns clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: register contents as the datasheet describes them
    logic [7:0]  m_filter = 8'h13;
    logic [7:0]  m_power  = 8'h00;
    logic [7:0]  m_shadow [6];
    logic [15:0] exp_wr [$];
    logic [15:0] got_wr [$];

    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        if (a == 8'h00) return 8'hAD;
        if (a == 8'h01) return 8'h1D;
        if (a == 8'h02) return 8'hF2;
        if (a >= 8'h0E && a <= 8'h13) return m_shadow[a - 8'h0E];
        if (a == 8'h2C) return m_filter;
        if (a == 8'h2D) return m_power;
        return 8'h00;
    endfunction

    task automatic model_wr(input logic [7:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
        if (a == 8'h2C) m_filter = d;
        else if (a == 8'h2D) m_power = d;
        else if (a == 8'h1F && d == 8'h52) begin
            m_filter = 8'h13;
            m_power  = 8'h00;
        end
    endtask

    task automatic model_reset();
        m_filter = 8'h13;
        m_power  = 8'h00;
        for (int i = 0; i < 6; i++) m_shadow[i] = 8'h00;
        exp_wr.delete();
    endtask

    // Every clock with reg_wr high is logged, so a stretched pulse shows up as an extra entry
    always @(negedge clk) begin
        if (reg_wr) got_wr.push_back({reg_wr_addr, reg_wr_data});
    end

    task automatic rand_axes();
        x_in = 16'($urandom);
        y_in = 16'($urandom);
        z_in = 16'($urandom);
    endtask

    task automatic spi_byte(input logic [7:0] d, input int nb, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nb; i++) begin
            spi_mosi = d[7-i];
            #HALF;
            r[7-i]   = spi_miso;
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
    endtask

    // One CS-framed transaction; last byte may be cut short, axes may change after the first byte
    task automatic run_xact(input int nbytes, input int last_bits, input bit scramble);
        logic [7:0] r;
        spi_cs_n = 1'b0;
        m_shadow[0] = x_in[7:0];
        m_shadow[1] = x_in[15:8];
        m_shadow[2] = y_in[7:0];
        m_shadow[3] = y_in[15:8];
        m_shadow[4] = z_in[7:0];
        m_shadow[5] = z_in[15:8];
        #HALF;
        for (int b = 0; b < nbytes; b++) begin
            spi_byte(tx_buf[b], (b == nbytes - 1) ? last_bits : 8, r);
            rx_buf[b] = r;
            if (b == 0 && scramble) rand_axes();
        end
        #HALF;
        spi_cs_n = 1'b1;
        #(6 * HALF);
    endtask

    task automatic check_state(input string tag);
        chk({tag, " power_ctl"}, 32'(power_ctl), 32'(m_power));
        chk({tag, " measure_en"}, 32'(measure_en), 32'(m_power[1:0] == 2'b10));
        chk({tag, " wr_count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            chk({tag, " wr_entry"}, 32'(got_wr[i]), 32'(exp_wr[i]));
        chk({tag, " miso_idle"}, 32'(spi_miso), 32'd0);
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input int n, input bit scramble);
        tx_buf[0] = 8'h0B;
        tx_buf[1] = a;
        for (int i = 0; i < n; i++) tx_buf[2+i] = 8'h00;
        run_xact(n + 2, 8, scramble);
        chk({tag, " miso_cmd"}, 32'({rx_buf[0], rx_buf[1]}), 32'd0);
        for (int i = 0; i < n; i++)
            chk({tag, " rd"}, 32'(rx_buf[2+i]), 32'(model_rd(a + 8'(i))));
        check_state(tag);
    endtask

    // Writes n full data bytes, then optionally a truncated byte of pbits bits
    task automatic do_write(input string tag, input logic [7:0] a, input int n, input int pbits);
        int total;
        tx_buf[0] = 8'h0A;
        tx_buf[1] = a;
        total = n + 2 + ((pbits > 0) ? 1 : 0);
        for (int i = 2; i < total; i++) begin
            tx_buf[i] = ($urandom_range(0, 3) == 0) ? 8'h52 : 8'($urandom);
        end
        run_xact(total, (pbits > 0) ? pbits : 8, 1'b0);
        for (int i = 0; i < n; i++) model_wr(a + 8'(i), tx_buf[2+i]);
        for (int i = 0; i < total; i++) chk({tag, " miso_w"}, 32'(rx_buf[i]), 32'd0);
        check_state(tag);
    endtask

    function automatic logic [7:0] pick_addr();
        logic [7:0] lst [14];
        lst = '{8'h00, 8'h01, 8'h02, 8'h0E, 8'h0F, 8'h10, 8'h11,
                8'h12, 8'h13, 8'h1F, 8'h2C, 8'h2D, 8'hFF, 8'h2B};
        if ($urandom_range(0, 4) == 0) return 8'($urandom);
        return lst[$urandom_range(0, 13)];
    endfunction

    initial begin
        logic [7:0] r;
        model_reset();
        #2ns;
        #100ns;
        chk("rst miso", 32'(spi_miso), 32'd0);
        chk("rst power_ctl", 32'(power_ctl), 32'h00);
        chk("rst measure_en", 32'(measure_en), 32'd0);
        chk("rst reg_wr", 32'(reg_wr), 32'd0);
        chk("rst wr_addr", 32'(reg_wr_addr), 32'h00);
        chk("rst wr_data", 32'(reg_wr_data), 32'h00);
        reset = 1'b0;
        #100ns;

        // Write POWER_CTL = 0x02: one pulse, measure mode on
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h2D; tx_buf[2] = 8'h02;
        run_xact(3, 8, 1'b0);
        model_wr(8'h2D, 8'h02);
        chk("measure on", 32'(measure_en), 32'd1);
        check_state("w2d");

        // Z snapshot, little-endian, insensitive to mid-transaction changes
        z_in = 16'shFF38;
        tx_buf[0] = 8'h0B; tx_buf[1] = 8'h12; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
        run_xact(4, 8, 1'b1);
        chk("z_l", 32'(rx_buf[2]), 32'h38);
        chk("z_h", 32'(rx_buf[3]), 32'hFF);
        check_state("zrd");

        // ID registers then pointer wrap from 0xFF
        do_read("ids", 8'h00, 3, 1'b0);
        chk("id2", 32'(rx_buf[4]), 32'hF2);
        do_read("wrap", 8'hFF, 2, 1'b0);
        chk("wrap0", 32'(rx_buf[2]), 32'h00);
        chk("wrap1", 32'(rx_buf[3]), 32'hAD);

        // Aborted write after 5 bits of data
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h2D; tx_buf[2] = 8'hFF;
        run_xact(3, 5, 1'b0);
        chk("abort power", 32'(power_ctl), 32'h02);
        check_state("abort");

        // Unknown command is ignored, then soft reset
        tx_buf[0] = 8'h55; tx_buf[1] = 8'h2D; tx_buf[2] = 8'h02;
        run_xact(3, 8, 1'b0);
        for (int i = 0; i < 3; i++) chk("ign miso", 32'(rx_buf[i]), 32'd0);
        check_state("ign");
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h1F; tx_buf[2] = 8'h52;
        run_xact(3, 8, 1'b0);
        model_wr(8'h1F, 8'h52);
        chk("softrst power", 32'(power_ctl), 32'h00);
        check_state("softrst");
        do_read("filt", 8'h2C, 2, 1'b0);
        chk("filt rst", 32'(rx_buf[2]), 32'h13);

        // Reset pulse in the middle of a read of POWER_CTL
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h2D; tx_buf[2] = 8'h02;
        run_xact(3, 8, 1'b0);
        model_wr(8'h2D, 8'h02);
        check_state("pre_rst");
        spi_cs_n = 1'b0;
        #HALF;
        spi_byte(8'h0B, 8, r);
        spi_byte(8'h2D, 8, r);
        spi_byte(8'h00, 3, r);
        reset = 1'b1;
        #30ns;
        chk("midrst miso", 32'(spi_miso), 32'd0);
        chk("midrst power", 32'(power_ctl), 32'h00);
        spi_cs_n = 1'b1;
        #HALF;
        reset = 1'b0;
        model_reset();
        got_wr.delete();
        #(4 * HALF);
        do_read("postrst", 8'h2D, 1, 1'b0);
        chk("postrst val", 32'(rx_buf[2]), 32'h00);

        // Randomized mix of reads, writes, aborted writes and bad commands
        for (int t = 0; t < 40; t++) begin
            rand_axes();
            case ($urandom_range(0, 3))
                0: do_read("rnd_rd", pick_addr(), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
                1: do_write("rnd_wr", ($urandom_range(0, 1) == 0) ? 8'h2D : pick_addr(),
                            $urandom_range(1, 2), 0);
                2: do_write("rnd_ab", pick_addr(), $urandom_range(0, 1), $urandom_range(1, 7));
                default: begin
                    tx_buf[0] = 8'($urandom_range(16, 255));
                    tx_buf[1] = 8'h2D;
                    tx_buf[2] = 8'($urandom);
                    run_xact(3, 8, 1'b0);
                    for (int i = 0; i < 3; i++) chk("rnd_ign miso", 32'(rx_buf[i]), 32'd0);
                    check_state("rnd_ign");
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
